// File: rtl/uart_regif.sv
// Memory-interface register slave for the APB UART: config registers, TX/RX FIFO
// push/pop, sticky interrupt flags and a registered interrupt line.
module uart_regif #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    mreq_i,
   input  logic [ADDR_WIDTH-1:0]   maddr_i,
   input  logic                    mwe_i,
   input  logic [DATA_WIDTH-1:0]   mwdata_i,
   input  logic [DATA_WIDTH/8-1:0] mstrb_i,
   output logic                    mack_o,
   output logic [DATA_WIDTH-1:0]   mrdata_o,
   output logic                    mresp_o,
   output logic [4:0]              cfg_ctrl_o,
   output logic [31:0]             cfg_clkdiv_o,
   output logic                    tx_push_o,
   output logic [7:0]              tx_data_o,
   input  logic                    tx_full_i,
   input  logic                    tx_empty_i,
   output logic                    rx_pop_o,
   input  logic [7:0]              rx_data_i,
   input  logic                    rx_full_i,
   input  logic                    rx_empty_i,
   input  logic                    rx_ovf_i,
   input  logic                    rx_perr_i,
   output logic                    irq_o
);

   if (DATA_WIDTH != 32) begin : g_width_check
      $error("uart_regif: DATA_WIDTH must be 32");
   end

   localparam logic [2:0] IDX_CTRL     = 3'd0;
   localparam logic [2:0] IDX_CLKDIV   = 3'd1;
   localparam logic [2:0] IDX_STATUS   = 3'd2;
   localparam logic [2:0] IDX_TX       = 3'd3;
   localparam logic [2:0] IDX_RX       = 3'd4;
   localparam logic [2:0] IDX_INT_STAT = 3'd5;
   localparam logic [2:0] IDX_INT_EN   = 3'd6;

   logic [4:0]  ctrl_q, ctrl_d;
   logic [31:0] clkdiv_q, clkdiv_d;
   logic [1:0]  int_stat_q, int_stat_d;
   logic [1:0]  int_en_q, int_en_d;
   logic [1:0]  int_clr;
   logic        irq_q;
   logic        mack_q, resp_q, resp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [2:0]  idx;
   logic        aligned, wr_hit;

   // Only the low five address bits decode; the rest are deliberately ignored.
   logic unused_addr;
   assign unused_addr = ^maddr_i;

   assign idx     = maddr_i[4:2];
   assign aligned = (maddr_i[1:0] == 2'b00);
   assign wr_hit  = mreq_i & mwe_i & aligned;

   assign tx_push_o = wr_hit & (idx == IDX_TX) & mstrb_i[0] & ~tx_full_i;
   assign tx_data_o = mwdata_i[7:0];
   assign rx_pop_o  = mreq_i & ~mwe_i & aligned & (idx == IDX_RX) & ~rx_empty_i;

   always_comb begin
      ctrl_d   = ctrl_q;
      clkdiv_d = clkdiv_q;
      int_en_d = int_en_q;
      int_clr  = 2'b00;
      if (wr_hit && idx == IDX_CTRL && mstrb_i[0]) begin
         ctrl_d = mwdata_i[4:0];
      end
      if (wr_hit && idx == IDX_CLKDIV) begin
         for (int b = 0; b < 4; b++) begin
            if (mstrb_i[b]) begin
               clkdiv_d[8*b +: 8] = mwdata_i[8*b +: 8];
            end
         end
      end
      if (wr_hit && idx == IDX_INT_EN && mstrb_i[0]) begin
         int_en_d = mwdata_i[1:0];
      end
      if (wr_hit && idx == IDX_INT_STAT && mstrb_i[0]) begin
         int_clr = mwdata_i[1:0];
      end
      // Set is applied after clear so a coincident event keeps its flag.
      int_stat_d = (int_stat_q & ~int_clr) | {rx_perr_i, rx_ovf_i};
   end

   always_comb begin
      rdata_d = 32'h0;
      resp_d  = 1'b0;
      if (!aligned) begin
         resp_d = 1'b1;
      end else begin
         case (idx)
            IDX_CTRL: begin
               if (!mwe_i) rdata_d = {27'h0, ctrl_q};
            end
            IDX_CLKDIV: begin
               if (!mwe_i) rdata_d = clkdiv_q;
            end
            IDX_STATUS: begin
               if (mwe_i) resp_d = 1'b1;
               else rdata_d = {28'h0, rx_empty_i, rx_full_i, tx_empty_i, tx_full_i};
            end
            IDX_TX: begin
               if (mwe_i) resp_d = mstrb_i[0] & tx_full_i;
               else resp_d = 1'b1;
            end
            IDX_RX: begin
               if (mwe_i || rx_empty_i) resp_d = 1'b1;
               else rdata_d = {24'h0, rx_data_i};
            end
            IDX_INT_STAT: begin
               if (!mwe_i) rdata_d = {30'h0, int_stat_q};
            end
            IDX_INT_EN: begin
               if (!mwe_i) rdata_d = {30'h0, int_en_q};
            end
            default: resp_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q     <= '0;
         clkdiv_q   <= '0;
         int_stat_q <= '0;
         int_en_q   <= '0;
         irq_q      <= 1'b0;
         mack_q     <= 1'b0;
         rdata_q    <= '0;
         resp_q     <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         clkdiv_q   <= clkdiv_d;
         int_stat_q <= int_stat_d;
         int_en_q   <= int_en_d;
         irq_q      <= |(int_stat_d & int_en_d);
         mack_q     <= mreq_i;
         rdata_q    <= mreq_i ? rdata_d : 32'h0;
         resp_q     <= mreq_i & resp_d;
      end
   end

   assign mack_o       = mack_q;
   assign mrdata_o     = rdata_q;
   assign mresp_o      = resp_q;
   assign cfg_ctrl_o   = ctrl_q;
   assign cfg_clkdiv_o = clkdiv_q;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_uart_regif.sv
// Scoreboard bench for uart_regif: expected responses are queued at request time
// and checked by a negedge monitor; per-feature tasks check side-band outputs.
module tb_uart_regif;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mreq_i;
   logic [31:0] maddr_i;
   logic        mwe_i;
   logic [31:0] mwdata_i;
   logic [3:0]  mstrb_i;
   logic        mack_o;
   logic [31:0] mrdata_o;
   logic        mresp_o;
   logic [4:0]  cfg_ctrl_o;
   logic [31:0] cfg_clkdiv_o;
   logic        tx_push_o;
   logic [7:0]  tx_data_o;
   logic        tx_full_i;
   logic        tx_empty_i;
   logic        rx_pop_o;
   logic [7:0]  rx_data_i;
   logic        rx_full_i;
   logic        rx_empty_i;
   logic        rx_ovf_i;
   logic        rx_perr_i;
   logic        irq_o;

   int errors = 0;
   int checks = 0;
   logic [32:0] exp_q[$];

   uart_regif dut (
      .clk_i(clk_i), .rst_i(rst_i), .mreq_i(mreq_i), .maddr_i(maddr_i),
      .mwe_i(mwe_i), .mwdata_i(mwdata_i), .mstrb_i(mstrb_i), .mack_o(mack_o),
      .mrdata_o(mrdata_o), .mresp_o(mresp_o), .cfg_ctrl_o(cfg_ctrl_o),
      .cfg_clkdiv_o(cfg_clkdiv_o), .tx_push_o(tx_push_o), .tx_data_o(tx_data_o),
      .tx_full_i(tx_full_i), .tx_empty_i(tx_empty_i), .rx_pop_o(rx_pop_o),
      .rx_data_i(rx_data_i), .rx_full_i(rx_full_i), .rx_empty_i(rx_empty_i),
      .rx_ovf_i(rx_ovf_i), .rx_perr_i(rx_perr_i), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   // Response monitor: every ack pops one expectation; idle cycles must show zeros.
   always @(negedge clk_i) begin
      logic [32:0] e;
      checks++;
      if (mack_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: got mack_o=1 resp=%b rdata=%h, expected no ack",
                     mresp_o, mrdata_o);
         end else begin
            e = exp_q.pop_front();
            if ({mresp_o, mrdata_o} !== e) begin
               errors++;
               $display("FAIL response: got resp=%b rdata=%h, expected resp=%b rdata=%h",
                        mresp_o, mrdata_o, e[32], e[31:0]);
            end
         end
      end else if (mack_o !== 1'b0 || mrdata_o !== 32'h0 || mresp_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_bus: got mack=%b resp=%b rdata=%h, expected all zero",
                  mack_o, mresp_o, mrdata_o);
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      mreq_i   = 1'b0;
      mwe_i    = 1'b0;
      maddr_i  = 32'h0;
      mwdata_i = 32'h0;
      mstrb_i  = 4'h0;
   endtask

   task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] er, input logic ep);
      mreq_i   = 1'b1;
      maddr_i  = a;
      mwe_i    = we;
      mwdata_i = wd;
      mstrb_i  = st;
      exp_q.push_back({ep, er});
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle();
      repeat (3) step();
      rst_i = 1'b0;
      checks++;
      if (cfg_ctrl_o !== 5'h0 || cfg_clkdiv_o !== 32'h0 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got ctrl=%h clkdiv=%h irq=%b, expected 0 0 0",
                  cfg_ctrl_o, cfg_clkdiv_o, irq_o);
      end
      drive(32'h00, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      drive(32'h04, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      drive(32'h08, 1'b0, 32'h0, 4'h0, 32'hA, 1'b0);
      step();
      drive(32'h14, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      drive(32'h18, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      idle();
   endtask

   task automatic test_config();
      drive(32'h04, 1'b1, 32'hDEADBEEF, 4'b0101, 32'h0, 1'b0);
      step();
      idle();
      checks++;
      if (cfg_clkdiv_o !== 32'h00AD00EF) begin
         errors++;
         $display("FAIL clkdiv_cfg: got %h, expected 00ad00ef", cfg_clkdiv_o);
      end
      drive(32'h04, 1'b0, 32'h0, 4'h0, 32'h00AD00EF, 1'b0);
      step();
      drive(32'h04, 1'b1, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
      step();
      drive(32'h04, 1'b0, 32'h0, 4'h0, 32'h00AD00EF, 1'b0);
      step();
      drive(32'h00, 1'b1, 32'h3F, 4'b0001, 32'h0, 1'b0);
      step();
      idle();
      checks++;
      if (cfg_ctrl_o !== 5'h1F) begin
         errors++;
         $display("FAIL ctrl_cfg: got %h, expected 1f", cfg_ctrl_o);
      end
      drive(32'h00, 1'b0, 32'h0, 4'h0, 32'h1F, 1'b0);
      step();
      drive(32'h18, 1'b1, 32'hFF, 4'b0000, 32'h0, 1'b0);
      step();
      drive(32'h18, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      idle();
   endtask

   task automatic test_status();
      tx_full_i  = 1'b1;
      tx_empty_i = 1'b0;
      rx_full_i  = 1'b1;
      rx_empty_i = 1'b0;
      drive(32'h08, 1'b0, 32'h0, 4'h0, 32'h5, 1'b0);
      #1;
      checks++;
      if (rx_pop_o !== 1'b0 || tx_push_o !== 1'b0) begin
         errors++;
         $display("FAIL status_side_effect: got pop=%b push=%b, expected 0 0", rx_pop_o, tx_push_o);
      end
      step();
      drive(32'h08, 1'b1, 32'hF, 4'hF, 32'h0, 1'b1);
      step();
      idle();
      tx_full_i  = 1'b0;
      tx_empty_i = 1'b1;
      rx_full_i  = 1'b0;
      rx_empty_i = 1'b1;
      step();
   endtask

   task automatic test_tx();
      drive(32'h0C, 1'b1, 32'h1A5, 4'hF, 32'h0, 1'b0);
      #1;
      checks++;
      if (tx_push_o !== 1'b1 || tx_data_o !== 8'hA5) begin
         errors++;
         $display("FAIL tx_push: got push=%b data=%h, expected 1 a5", tx_push_o, tx_data_o);
      end
      step();
      idle();
      tx_full_i = 1'b1;
      drive(32'h0C, 1'b1, 32'h1A5, 4'hF, 32'h0, 1'b1);
      #1;
      checks++;
      if (tx_push_o !== 1'b0) begin
         errors++;
         $display("FAIL tx_full_push: got push=%b, expected 0", tx_push_o);
      end
      step();
      tx_full_i = 1'b0;
      drive(32'h0C, 1'b1, 32'h77, 4'b1110, 32'h0, 1'b0);
      #1;
      checks++;
      if (tx_push_o !== 1'b0) begin
         errors++;
         $display("FAIL tx_nostrb_push: got push=%b, expected 0", tx_push_o);
      end
      step();
      drive(32'h0C, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      step();
      idle();
   endtask

   task automatic test_rx();
      logic [7:0] fifo[$];
      fifo = '{8'h11, 8'h22};
      rx_empty_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rx_data_i = fifo[0];
         drive(32'h10, 1'b0, 32'h0, 4'h0, {24'h0, fifo[0]}, 1'b0);
         #1;
         checks++;
         if (rx_pop_o !== 1'b1) begin
            errors++;
            $display("FAIL rx_pop_%0d: got pop=%b, expected 1", i, rx_pop_o);
         end
         step();
         void'(fifo.pop_front());
      end
      rx_empty_i = 1'b1;
      drive(32'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      #1;
      checks++;
      if (rx_pop_o !== 1'b0) begin
         errors++;
         $display("FAIL rx_empty_pop: got pop=%b, expected 0", rx_pop_o);
      end
      step();
      drive(32'h10, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1);
      step();
      idle();
   endtask

   task automatic test_irq();
      drive(32'h18, 1'b1, 32'h1, 4'b0001, 32'h0, 1'b0);
      step();
      idle();
      rx_ovf_i = 1'b1;
      #1;
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_early: got %b, expected 0", irq_o);
      end
      step();
      rx_ovf_i = 1'b0;
      checks++;
      if (irq_o !== 1'b1) begin
         errors++;
         $display("FAIL irq_set: got %b, expected 1", irq_o);
      end
      drive(32'h14, 1'b1, 32'h1, 4'b0001, 32'h0, 1'b0);
      rx_ovf_i = 1'b1;
      step();
      idle();
      rx_ovf_i = 1'b0;
      checks++;
      if (irq_o !== 1'b1) begin
         errors++;
         $display("FAIL irq_set_wins: got %b, expected 1", irq_o);
      end
      drive(32'h14, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0);
      step();
      drive(32'h14, 1'b1, 32'h1, 4'b0001, 32'h0, 1'b0);
      step();
      idle();
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear: got %b, expected 0", irq_o);
      end
      drive(32'h14, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      idle();
      rx_perr_i = 1'b1;
      step();
      rx_perr_i = 1'b0;
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_masked: got %b, expected 0", irq_o);
      end
      drive(32'h14, 1'b0, 32'h0, 4'h0, 32'h2, 1'b0);
      step();
      drive(32'h14, 1'b1, 32'h2, 4'b0001, 32'h0, 1'b0);
      step();
      drive(32'h14, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      idle();
   endtask

   task automatic test_errors();
      drive(32'h02, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      step();
      drive(32'h1C, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      step();
      drive(32'h1C, 1'b1, 32'h1234, 4'hF, 32'h0, 1'b1);
      step();
      drive(32'h01, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1);
      step();
      drive(32'h00, 1'b0, 32'h0, 4'h0, 32'h1F, 1'b0);
      step();
      drive(32'hFFFFFFE4, 1'b0, 32'h0, 4'h0, 32'h00AD00EF, 1'b0);
      step();
      idle();
   endtask

   task automatic test_back_to_back();
      drive(32'h00, 1'b1, 32'h0A, 4'b0001, 32'h0, 1'b0);
      step();
      drive(32'h00, 1'b0, 32'h0, 4'h0, 32'h0A, 1'b0);
      step();
      drive(32'h04, 1'b0, 32'h0, 4'h0, 32'h00AD00EF, 1'b0);
      step();
      drive(32'h04, 1'b1, 32'h01, 4'b0001, 32'h0, 1'b0);
      step();
      drive(32'h04, 1'b0, 32'h0, 4'h0, 32'h00AD0001, 1'b0);
      step();
      idle();
   endtask

   task automatic test_reset_inflight();
      drive(32'h18, 1'b1, 32'h3, 4'b0001, 32'h0, 1'b0);
      step();
      idle();
      rx_perr_i = 1'b1;
      step();
      rx_perr_i = 1'b0;
      checks++;
      if (irq_o !== 1'b1) begin
         errors++;
         $display("FAIL irq_before_reset: got %b, expected 1", irq_o);
      end
      mreq_i   = 1'b1;
      mwe_i    = 1'b1;
      maddr_i  = 32'h04;
      mwdata_i = 32'h12345678;
      mstrb_i  = 4'hF;
      rst_i    = 1'b1;
      step();
      rst_i = 1'b0;
      idle();
      checks++;
      if (mack_o !== 1'b0 || cfg_clkdiv_o !== 32'h0 || cfg_ctrl_o !== 5'h0 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_inflight: got ack=%b clkdiv=%h ctrl=%h irq=%b, expected 0 0 0 0",
                  mack_o, cfg_clkdiv_o, cfg_ctrl_o, irq_o);
      end
      drive(32'h00, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      drive(32'h04, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      drive(32'h14, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      drive(32'h18, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      step();
      idle();
   endtask

   initial begin
      rst_i      = 1'b1;
      tx_full_i  = 1'b0;
      tx_empty_i = 1'b1;
      rx_full_i  = 1'b0;
      rx_empty_i = 1'b1;
      rx_data_i  = 8'h0;
      rx_ovf_i   = 1'b0;
      rx_perr_i  = 1'b0;
      idle();
      test_reset();
      test_config();
      test_status();
      test_tx();
      test_rx();
      test_irq();
      test_errors();
      test_back_to_back();
      test_reset_inflight();
      repeat (3) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
